logic_op_arbiter: RTL and testbench

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

---
 rtl/logic_op_arbiter_pkg.sv | 20 ++
 rtl/logic_op_arbiter_unit.sv | 24 ++
 rtl/logic_op_arbiter.sv | 123 ++++++++++++
 tb/tb_logic_op_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_arbiter_pkg.sv
// Shared types and defaults for the round-robin logic-op arbiter and its datapath.
package logic_op_arbiter_pkg;

  localparam int DEFAULT_NREQ  = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_op_arbiter_unit.sv
// Combinational bitwise logic unit: y = a <op> b, exactly WIDTH bits wide.
module logic_op_unit
  import logic_op_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter giving NREQ requesters shared use of one logic_op_unit,
// one transaction in flight at a time (IDLE -> EXEC -> RESP).
module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output state_e                dbg_state
);

  // Handshake: a request transfers on an edge where req_valid[i] && req_ready[i];
  // a result transfers on an edge where rsp_valid[id] && rsp_ready[id].
  localparam int GW = $clog2(NREQ);
  localparam logic [GW:0]     NREQ_W = (GW+1)'(NREQ);
  localparam logic [NREQ-1:0] ONE    = NREQ'(1);

  state_e            state, state_next;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     win;
  logic [GW:0]       cand;
  logic              any_valid;
  logic              accept;
  logic [WIDTH-1:0]  a_q, b_q;
  op_e               op_q;
  logic [GW-1:0]     id_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic [WIDTH-1:0]  unit_y;

  // Search starts just after the previous winner and wraps past NREQ-1 to 0.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, last_grant} + (GW+1)'(off);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!any_valid && req_valid[cand[GW-1:0]]) begin
        any_valid = 1'b1;
        win       = cand[GW-1:0];
      end
    end
  end

  assign accept = (state == IDLE) && any_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[id_q]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while rst_n is asserted, not only after the edge.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: if (any_valid) req_ready = ONE << win;
        EXEC: busy = 1'b1;
        RESP: begin
          busy      = 1'b1;
          rsp_valid = ONE << id_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= GW'(NREQ-1);
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
      id_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        a_q  <= req_a[win*WIDTH +: WIDTH];
        b_q  <= req_b[win*WIDTH +: WIDTH];
        op_q <= op_e'(req_op[win*2 +: 2]);
        id_q <= win;
      end
      if (state == EXEC) rsp_data_q <= unit_y;
      if (state == RESP && rsp_ready[id_q]) last_grant <= id_q;
    end
  end

  logic_op_unit #(.WIDTH(WIDTH)) u_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (unit_y)
  );

  assign rsp_data  = rsp_data_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: reset, single ops, round-robin order,
// backpressure, reset mid-response and request withdrawal.
module tb_logic_op_arbiter;
  import logic_op_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_op;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
  state_e                dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [1:0]       gnt_q[$];

  logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input op_e op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*2 +: 2]        = op;
  endtask

  task automatic do_single(input int i, input logic [7:0] a, input logic [7:0] b,
                           input op_e op, input logic [7:0] exp);
    set_req(i, a, b, op);
    req_valid = NREQ'(oh(i));
    #1;
    chk("single_grant", 32'(req_ready), oh(i));
    tick();
    req_valid = '0;
    #1;
    chk("single_exec_busy", 32'(busy), 32'(1));
    chk("single_exec_no_rsp", 32'(rsp_valid), 32'(0));
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), oh(i));
    chk("single_rsp_data", 32'(rsp_data), 32'(exp));
    tick();
    chk("single_back_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    logic [1:0]       g;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] rr_a   [NREQ];
    logic [WIDTH-1:0] rr_b   [NREQ];
    op_e              rr_op  [NREQ];
    logic [WIDTH-1:0] rr_exp [NREQ];

    rr_a   = '{8'hC3, 8'h5A, 8'hF0, 8'h99};
    rr_b   = '{8'h0F, 8'hFF, 8'h33, 8'hA5};
    rr_op  = '{OP_AND, OP_OR, OP_XOR, OP_NAND};
    rr_exp = '{8'h03, 8'hFF, 8'hC3, 8'h7E};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '1;

    // reset state, with requests present while in reset
    tick();
    req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    tick();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    req_valid = '0;
    rst_n     = 1'b1;

    // single request and opcode sweep on a lone requester
    do_single(0, 8'hF0, 8'h3C, OP_AND,  8'h30);
    do_single(0, 8'hAA, 8'h0F, OP_OR,   8'hAF);
    do_single(0, 8'hAA, 8'h0F, OP_XOR,  8'hA5);
    do_single(0, 8'hAA, 8'h0F, OP_NAND, 8'hF5);
    do_single(0, 8'hAA, 8'h0F, OP_AND,  8'h0A);

    // all requesters valid: order 0,1,2,3,0 at one grant every 3 cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, rr_a[i], rr_b[i], rr_op[i]);
    foreach (rr_exp[i]) begin
      gnt_q.push_back(2'(i));
      exp_q.push_back(rr_exp[i]);
    end
    gnt_q.push_back(2'd0);
    exp_q.push_back(rr_exp[0]);
    req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      g = gnt_q.pop_front();
      e = exp_q.pop_front();
      #1;
      chk("rr_grant", 32'(req_ready), oh(int'(g)));
      chk("rr_state_idle", 32'(dbg_state), 32'(IDLE));
      tick();
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), oh(int'(g)));
      chk("rr_rsp_data", 32'(rsp_data), 32'(e));
      tick();
    end

    // backpressure on requester 2; rsp_ready[1] must be ignored
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    #1;
    chk("bp_grant", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
      chk("bp_rsp_data", 32'(rsp_data), 32'(rr_exp[2]));
      chk("bp_req_ready", 32'(req_ready), 32'(0));
      chk("bp_busy", 32'(busy), 32'(1));
      if (k == 4) rsp_ready = '1;
      tick();
    end
    chk("bp_next_grant", 32'(req_ready), 32'(4'b1000));
    req_valid = '0;
    #1;
    chk("bp_idle", 32'(busy), 32'(0));

    // reset during RESP aborts the response
    req_valid = 4'b0010;
    rsp_ready = '0;
    #1;
    chk("mr_grant", 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = '0;
    tick();
    chk("mr_in_resp", 32'(rsp_valid), 32'(4'b0010));
    rst_n = 1'b0;
    #1;
    chk("mr_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mr_rst_busy", 32'(busy), 32'(0));
    tick();
    rst_n     = 1'b1;
    rsp_ready = '1;
    #1;
    chk("mr_state", 32'(dbg_state), 32'(IDLE));
    chk("mr_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    req_valid = '1;
    #1;
    chk("mr_next_grant", 32'(req_ready), 32'(4'b0001));

    // withdrawal: requester 1 pulses valid while busy and is never granted
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1;
    chk("wd_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("wd_no_grant", 32'(req_ready), 32'(0));
      chk("wd_idle", 32'(busy), 32'(0));
      tick();
    end
    req_valid = 4'b0100;
    #1;
    chk("wd_skip_to_2", 32'(req_ready), 32'(4'b0100));
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
